reg_bcd_formatter: RTL
======================

Name: reg_bcd_formatter

Overview:
- Sequential binary-to-BCD converter for the debug display path.
- Sits between the core's register-observation outputs (RegisterContent / RegData) and LCD_Controller, which consumes Sign and 4-bit decimal digits.
- Replaces the 2-digit combinational compare chain with an iterative shift-add-3 (double-dabble) engine. It covers full 32-bit signed or unsigned values and uses a start/done handshake.

Parameters:
- NUM_DIGITS, 10: number of BCD output digits. 10 covers the full 32-bit range; smaller values enable overflow saturation.
- DATA_W, 32: width of the input value.

Ports:
- clk  in  1: single clock (Master_clk domain).
- reset  in  1: asynchronous, active-low reset.
- start  in  1: request conversion of value; sampled only in IDLE.
- value  in  DATA_W: word to convert (register content).
- signed_mode  in  1: 1 = two's-complement input, 0 = unsigned.
- busy  out  1: high while a conversion is in progress.
- done  out  1: one-cycle pulse when sign/digits/overflow are updated.
- sign  out  1: 1 = negative result (signed_mode only).
- digits  out  4*NUM_DIGITS: BCD digits, digit 0 (least significant) in bits [3:0].
- overflow  out  1: magnitude exceeded 10^NUM_DIGITS-1.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE; busy=0, done=0, sign=0, overflow=0, digits=0.
  - Shift register, BCD accumulator and bit counter are cleared.
  - Reset mid-conversion aborts immediately. No done pulse follows.
- FSM states: IDLE, CONV, FINISH.
  - IDLE: on the edge where start=1, capture value and signed_mode.
    - sign_int = signed_mode & value[DATA_W-1].
    - mag = sign_int ? (~value+1) : value, taken as DATA_W-bit unsigned, so 0x80000000 gives magnitude 2^31.
    - Clear the BCD accumulator and the overflow sticky bit; count=DATA_W-1; go to CONV.
  - CONV: each cycle:
    - Add 3 to every accumulator digit >= 5.
    - Shift {acc, mag} left by one.
    - Set the overflow sticky bit if the bit shifted out of the top digit is 1.
    - Decrement count. After DATA_W shifts (count reaches 0 on the last one), go to FINISH.
  - FINISH: register the outputs and pulse done=1 for one cycle; go to IDLE.
    - sign <= sign_int, except sign is forced to 0 when the magnitude is 0.
    - digits <= acc; if overflow, digits <= all 4'd9.
- busy = (state != IDLE).
- Latency: start sampled at edge k; shifts on edges k+1..k+DATA_W; done visible after edge k+DATA_W+1 (33 clocks at default).
- start while busy is ignored, with no queuing.
- start during the done cycle is accepted, since the FSM is already IDLE.
- value and signed_mode may change freely after the capture edge.
- Outputs hold the last result until the next done.
- Overflow is impossible for NUM_DIGITS >= ceil(DATA_W*log10 2), i.e. 10 at default.

Optional Feature:
- Macro: REG_BCD_LEADING_ZERO_BLANK_EN.
- Defined: at FINISH, each digit above the most significant non-zero digit is replaced with 4'hF (LCD blank code). Digit 0 is never blanked, so value 0 shows a single "0". An overflow result (all 9s) is unaffected.
- Undefined: leading digits are output as 4'd0.

Decomposition:
- Package reg_bcd_pkg: FSM state encoding (IDLE/CONV/FINISH), BCD_BLANK=4'hF, BCD_NINE=4'd9, and the default DATA_W/NUM_DIGITS constants.
- Sub-module bcd_add3_digit: one combinational 4-bit correction (d>=5 ? d+3 : d), instantiated NUM_DIGITS times in a generate loop. All sequential logic stays in reg_bcd_formatter.

Test Plan:
- signed_mode=1, value=0xFFFFFFD6 (-42): sign=1, digits=0000000042, overflow=0. done appears exactly 33 clocks after start, busy is high for 33 cycles, and done lasts one cycle.
- signed_mode=1, value=0x80000000: sign=1, digits=2147483648. signed_mode=0, value=0xFFFFFFFF: sign=0, digits=4294967295.
- value=0 (signed): sign=0, digits all 0. With REG_BCD_LEADING_ZERO_BLANK_EN: digits=FFFFFFFFF0.
- NUM_DIGITS=2, unsigned, value=123: overflow=1, digits=99. Then value=57: overflow=0, digits=57.
- Start with value=10, then pulse start with value=99 at cycle 5 while busy: the second start is ignored and the result is 10. A start in the done cycle with value=7 is accepted and yields 07 after 33 clocks.
- Assert reset at cycle 12 of a conversion: busy=0 and all outputs 0 asynchronously, with no done pulse afterwards. The next start converts correctly.

Source files
------------

// File: rtl/reg_bcd_pkg.sv
// Shared constants for the register-observation BCD formatter.
// Holds the FSM encoding, the BCD special codes and the default sizes.
package reg_bcd_pkg;

   localparam int unsigned DATA_W_DEF     = 32;
   localparam int unsigned NUM_DIGITS_DEF = 10;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CONV   = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;

   localparam logic [3:0] BCD_BLANK = 4'hF;
   localparam logic [3:0] BCD_NINE  = 4'd9;

   // Double-dabble pre-shift correction for one BCD digit
   function automatic logic [3:0] bcd_add3(input logic [3:0] d);
      return (d >= 4'd5) ? (d + 4'd3) : d;
   endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Combinational add-3 correction for a single BCD digit of the
// double-dabble accumulator.
module bcd_add3_digit
   import reg_bcd_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit_c
);

   assign o_digit_c = bcd_add3(i_digit);

endmodule

// File: rtl/reg_bcd_formatter.sv
// Iterative binary-to-BCD converter feeding the debug LCD path.
// Optional macro REG_BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module reg_bcd_formatter
   import reg_bcd_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF
)
(
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_start,
   input  logic [DATA_W-1:0]       i_value,
   input  logic                    i_signed_mode,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_sign,
   output logic [4*NUM_DIGITS-1:0] o_digits,
   output logic                    o_overflow
);

   localparam int unsigned ACC_W = 4 * NUM_DIGITS;
   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic [1:0]        r_state,    w_state_nxt;
   logic [DATA_W-1:0] r_mag,      w_mag_nxt;
   logic [ACC_W-1:0]  r_acc,      w_acc_nxt;
   logic [CNT_W-1:0]  r_cnt,      w_cnt_nxt;
   logic              r_sign_int, w_sign_int_nxt;
   logic              r_zero,     w_zero_nxt;
   logic              r_ovf,      w_ovf_nxt;
   logic              r_busy,     w_busy_nxt;
   logic              r_done,     w_done_nxt;
   logic              r_sign,     w_sign_nxt;
   logic [ACC_W-1:0]  r_digits,   w_digits_nxt;
   logic              r_overflow, w_overflow_nxt;

   logic              w_neg;
   logic [DATA_W-1:0] w_mag_in;
   logic [ACC_W-1:0]  w_acc_adj;
   logic [ACC_W-1:0]  w_final;

   // Magnitude of the incoming word; 2^(DATA_W-1) stays representable as unsigned
   assign w_neg    = i_signed_mode & i_value[DATA_W-1];
   assign w_mag_in = w_neg ? (~i_value + DATA_W'(1)) : i_value;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
      bcd_add3_digit u_add3 (
         .i_digit   (r_acc[4*g +: 4]),
         .o_digit_c (w_acc_adj[4*g +: 4])
      );
   end

   // Result word presented at FINISH: saturation, then optional blanking
   always_comb begin
`ifdef REG_BCD_LEADING_ZERO_BLANK_EN
      logic w_lead;
      w_lead  = 1'b1;
`endif
      w_final = r_acc;
      if (r_ovf) begin
         w_final = {NUM_DIGITS{BCD_NINE}};
      end else begin
`ifdef REG_BCD_LEADING_ZERO_BLANK_EN
         for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            if (w_lead && (r_acc[4*i +: 4] == 4'd0)) begin
               w_final[4*i +: 4] = BCD_BLANK;
            end else begin
               w_lead = 1'b0;
            end
         end
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt    = r_state;
      w_mag_nxt      = r_mag;
      w_acc_nxt      = r_acc;
      w_cnt_nxt      = r_cnt;
      w_sign_int_nxt = r_sign_int;
      w_zero_nxt     = r_zero;
      w_ovf_nxt      = r_ovf;
      w_done_nxt     = 1'b0;
      w_sign_nxt     = r_sign;
      w_digits_nxt   = r_digits;
      w_overflow_nxt = r_overflow;

      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_mag_nxt      = w_mag_in;
               w_sign_int_nxt = w_neg;
               w_zero_nxt     = (w_mag_in == '0);
               w_acc_nxt      = '0;
               w_ovf_nxt      = 1'b0;
               w_cnt_nxt      = CNT_W'(DATA_W - 1);
               w_state_nxt    = ST_CONV;
            end
         end
         ST_CONV: begin
            // A set bit leaving the top digit means the value does not fit
            w_acc_nxt = {w_acc_adj[ACC_W-2:0], r_mag[DATA_W-1]};
            w_mag_nxt = r_mag << 1;
            w_ovf_nxt = r_ovf | w_acc_adj[ACC_W-1];
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == '0) begin
               w_state_nxt = ST_FINISH;
            end
         end
         ST_FINISH: begin
            w_done_nxt     = 1'b1;
            w_sign_nxt     = r_sign_int & ~r_zero;
            w_digits_nxt   = w_final;
            w_overflow_nxt = r_ovf;
            w_state_nxt    = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state    <= ST_IDLE;
         r_mag      <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_sign_int <= 1'b0;
         r_zero     <= 1'b0;
         r_ovf      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_sign     <= 1'b0;
         r_digits   <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_mag      <= w_mag_nxt;
         r_acc      <= w_acc_nxt;
         r_cnt      <= w_cnt_nxt;
         r_sign_int <= w_sign_int_nxt;
         r_zero     <= w_zero_nxt;
         r_ovf      <= w_ovf_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_sign     <= w_sign_nxt;
         r_digits   <= w_digits_nxt;
         r_overflow <= w_overflow_nxt;
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_sign     = r_sign;
   assign o_digits   = r_digits;
   assign o_overflow = r_overflow;

endmodule
